// File: rtl/led7219_rx.sv
// led7219_rx: oversampling receiver for the 3-wire MAX7219-style chain.
// Reassembles daisy-chained 16-bit words into per-device register writes
// and keeps a readable shadow copy of every device register.
module led7219_rx #(
  parameter int unsigned NDEV        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned DW         = (NDEV > 1) ? $clog2(NDEV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          leds_in,
  input  logic          leds_cs,
  input  logic          leds_clk,
  output logic          wr_valid,
  output logic [DW-1:0] wr_dev,
  output logic [3:0]    wr_addr,
  output logic [7:0]    wr_data,
  output logic          frame_err,
  output logic [15:0]   frame_cnt,
  output logic          busy,
  input  logic [DW-1:0] rd_dev,
  input  logic [3:0]    rd_addr,
  output logic [7:0]    rd_data
);

  localparam int unsigned FB = NDEV * 16;
  localparam int unsigned BW = $clog2(FB + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                  state, state_d;
  logic [SYNC_STAGES-1:0]  sy_dat, sy_cs, sy_sck;
  logic                    cs_q, sck_q;
  logic                    dat_s, cs_s, sck_s;
  logic                    cs_fall, cs_rise, sck_rise;
  logic [NDEV-1:0][15:0]   sreg;
  logic [NDEV-1:0][11:0]   snap;
  logic [BW-1:0]           bcnt;
  logic [DW-1:0]           dcnt, dcnt_d;
  logic                    act, act_d, pend, pend_d;
  logic                    shift_en, clr_bcnt, load_snap, word_en, err_d, inc_cnt;
  logic [11:0]             cur;
  logic [3:0]              cw_addr;
  logic [7:0]              cw_data;
  logic [NDEV-1:0][15:0][7:0] shadow;

  assign dat_s    = sy_dat[SYNC_STAGES-1];
  assign cs_s     = sy_cs[SYNC_STAGES-1];
  assign sck_s    = sy_sck[SYNC_STAGES-1];
  assign cs_fall  = ~cs_s & cs_q;
  assign cs_rise  = cs_s & ~cs_q;
  assign sck_rise = sck_s & ~sck_q;
  assign cur      = snap[dcnt];
  assign cw_addr  = cur[11:8];
  assign cw_data  = cur[7:0];

  // Input synchronizers plus one-cycle delayed copies for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sy_dat <= '0;
      sy_cs  <= '0;
      sy_sck <= '0;
      cs_q   <= 1'b0;
      sck_q  <= 1'b0;
    end else begin
      sy_dat <= SYNC_STAGES'({sy_dat, leds_in});
      sy_cs  <= SYNC_STAGES'({sy_cs, leds_cs});
      sy_sck <= SYNC_STAGES'({sy_sck, leds_clk});
      cs_q   <= cs_s;
      sck_q  <= sck_s;
    end
  end

  // FSM state and commit bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dcnt  <= '0;
      act   <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_d;
      dcnt  <= dcnt_d;
      act   <= act_d;
      pend  <= pend_d;
    end
  end

  // Next state and datapath controls; a new frame may be captured during COMMIT
  always_comb begin
    state_d   = state;
    dcnt_d    = dcnt;
    act_d     = act;
    pend_d    = pend;
    shift_en  = 1'b0;
    clr_bcnt  = 1'b0;
    load_snap = 1'b0;
    word_en   = 1'b0;
    err_d     = 1'b0;
    inc_cnt   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          clr_bcnt = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = sck_rise;
        if (cs_rise) begin
          if (bcnt == BW'(FB)) begin
            load_snap = 1'b1;
            dcnt_d    = '0;
            state_d   = COMMIT;
          end else begin
            err_d   = (bcnt != '0);
            state_d = IDLE;
          end
        end
      end
      COMMIT: begin
        word_en = 1'b1;
        if (act) begin
          shift_en = sck_rise;
          if (cs_rise) begin
            act_d = 1'b0;
            if (bcnt == BW'(FB)) pend_d = 1'b1;
            else                 err_d  = (bcnt != '0);
          end
        end else if (cs_fall) begin
          clr_bcnt = 1'b1;
          act_d    = 1'b1;
        end
        if (dcnt == DW'(NDEV - 1)) begin
          inc_cnt = 1'b1;
          dcnt_d  = '0;
          if (pend_d) begin
            load_snap = 1'b1;
            pend_d    = 1'b0;
          end else if (act_d) begin
            act_d   = 1'b0;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dcnt_d = dcnt + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register, saturating bit counter and commit snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      bcnt <= '0;
      snap <= '0;
    end else begin
      if (shift_en) sreg <= FB'({sreg, dat_s});
      if (clr_bcnt)                               bcnt <= '0;
      else if (shift_en && bcnt != BW'(FB + 1))   bcnt <= bcnt + BW'(1);
      if (load_snap) begin
        for (int k = 0; k < int'(NDEV); k++) snap[k] <= sreg[k][11:0];
      end
    end
  end

  // Write strobe, shadow update, status outputs and registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid  <= 1'b0;
      wr_dev    <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      busy      <= 1'b0;
      rd_data   <= '0;
      shadow    <= '0;
    end else begin
      wr_valid <= word_en && (cw_addr != 4'd0);
      if (word_en && (cw_addr != 4'd0)) begin
        wr_dev               <= dcnt;
        wr_addr              <= cw_addr;
        wr_data              <= cw_data;
        shadow[dcnt][cw_addr] <= cw_data;
      end
      frame_err <= err_d;
      frame_cnt <= frame_cnt + 16'(inc_cnt);
      busy      <= (state_d == COMMIT);
      if ((32'(rd_dev) < NDEV) && (rd_addr != 4'd0)) rd_data <= shadow[rd_dev][rd_addr];
      else                                            rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_led7219_rx.sv
// tb_led7219_rx: randomized frame stimulus checked against a behavioural
// model of the chained device registers.
module tb_led7219_rx;
  localparam int NDEV = 4;
  localparam int SS   = 2;

  typedef struct packed {
    logic [1:0] dev;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n, leds_in, leds_cs, leds_clk;
  logic        wr_valid, frame_err, busy;
  logic [1:0]  wr_dev, rd_dev;
  logic [3:0]  wr_addr, rd_addr;
  logic [7:0]  wr_data, rd_data;
  logic [15:0] frame_cnt;

  led7219_rx #(.NDEV(NDEV), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .leds_in(leds_in), .leds_cs(leds_cs), .leds_clk(leds_clk),
    .wr_valid(wr_valid), .wr_dev(wr_dev), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .busy(busy),
    .rd_dev(rd_dev), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  ev_t  ev_q[$];
  int   ev_cyc[$];
  int   err_seen = 0;
  int   busy_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs away from the active edge
  always @(negedge clk) begin
    if (wr_valid) begin
      ev_q.push_back('{wr_dev, wr_addr, wr_data});
      ev_cyc.push_back(cyc);
    end
    if (frame_err) err_seen++;
    if (busy) busy_seen++;
  end

  logic [7:0] mshadow [NDEV][16];
  int         mcnt = 0;
  ev_t        exp_q[$];
  int         rd_ptr = 0;
  int         rise_cyc = 0;
  int         total = 0;
  int         bad = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected effect of one accepted frame: device 0 holds the last-sent word
  task automatic model_frame(input logic [15:0] w [NDEV]);
    for (int d = 0; d < NDEV; d++) begin
      logic [15:0] word;
      word = w[NDEV-1-d];
      if (word[11:8] != 4'd0) begin
        exp_q.push_back('{2'(d), word[11:8], word[7:0]});
        mshadow[d][word[11:8]] = word[7:0];
      end
    end
    mcnt++;
  endtask

  task automatic model_clear();
    for (int d = 0; d < NDEV; d++)
      for (int a = 0; a < 16; a++) mshadow[d][a] = 8'h00;
    mcnt = 0;
  endtask

  // Send nclk shift clocks; words first, then random filler bits
  task automatic send_bits(input logic [15:0] w [NDEV], input int nclk, input int h);
    leds_cs = 1'b0;
    tick(h);
    for (int i = 0; i < nclk; i++) begin
      logic [15:0] word;
      if (i < 16*NDEV) begin
        word    = w[i/16];
        leds_in = word[15 - (i % 16)];
      end else begin
        leds_in = 1'($urandom);
      end
      leds_clk = 1'b0;
      tick(h);
      leds_clk = 1'b1;
      tick(h);
    end
    leds_clk = 1'b0;
    tick(h);
    leds_cs  = 1'b1;
    rise_cyc = cyc;
  endtask

  task automatic rand_words(output logic [15:0] w [NDEV]);
    for (int i = 0; i < NDEV; i++) w[i] = 16'($urandom);
  endtask

  task automatic check_events(input string nm);
    int n;
    n = ev_q.size() - rd_ptr;
    total++;
    if (n !== exp_q.size()) begin
      bad++;
      $display("FAIL %s event count: got %0d want %0d", nm, n, exp_q.size());
    end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      total++;
      if (ev_q[rd_ptr+i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s event %0d: got %h want %h", nm, i, ev_q[rd_ptr+i], exp_q[i]);
      end
    end
    rd_ptr = ev_q.size();
    exp_q.delete();
  endtask

  task automatic check_cnt(input string nm);
    total++;
    if (frame_cnt !== 16'(mcnt)) begin
      bad++;
      $display("FAIL %s frame_cnt: got %0d want %0d", nm, frame_cnt, mcnt);
    end
  endtask

  task automatic check_shadow(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      logic [1:0] d;
      logic [3:0] a;
      logic [7:0] e;
      d = 2'($urandom);
      a = (i == 0) ? 4'd0 : 4'($urandom);
      e = (a == 4'd0) ? 8'h00 : mshadow[d][a];
      rd_dev  = d;
      rd_addr = a;
      tick(1);
      total++;
      if (rd_data !== e) begin
        bad++;
        $display("FAIL %s read dev%0d addr%0h: got %h want %h", nm, d, a, rd_data, e);
      end
    end
  endtask

  task automatic check_outputs_zero(input string nm);
    total++;
    if ({wr_valid, wr_dev, wr_addr, wr_data, frame_err, frame_cnt, busy, rd_data} !== '0) begin
      bad++;
      $display("FAIL %s outputs: got %h want 0", nm,
               {wr_valid, wr_dev, wr_addr, wr_data, frame_err, frame_cnt, busy, rd_data});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    leds_cs = 1'b1; leds_clk = 1'b0; leds_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    model_clear();
    tick(5);
    rd_ptr = ev_q.size();
  endtask

  task automatic test_reset();
    rd_dev = '0; rd_addr = '0;
    rst_n = 1'b0;
    leds_cs = 1'b1; leds_clk = 1'b0; leds_in = 1'b0;
    tick(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    model_clear();
    tick(5);
    check_outputs_zero("post_reset");
    check_shadow("reset_shadow", 3);
  endtask

  task automatic test_basic();
    logic [15:0] w [NDEV];
    int b0, base, bs;
    w  = '{16'h0C01, 16'h0A05, 16'h0B07, 16'h0F00};
    b0 = rd_ptr;
    bs = busy_seen;
    model_frame(w);
    send_bits(w, 16*NDEV, 3);
    tick(20);
    base = b0;
    if (ev_q.size() - base == 4) begin
      for (int i = 1; i < 4; i++) begin
        total++;
        if (ev_cyc[base+i] !== ev_cyc[base] + i) begin
          bad++;
          $display("FAIL basic strobe spacing %0d: got %0d want %0d", i, ev_cyc[base+i] - ev_cyc[base], i);
        end
      end
      total++;
      if (ev_cyc[base] - rise_cyc !== SS + 2) begin
        bad++;
        $display("FAIL basic latency: got %0d want %0d", ev_cyc[base] - rise_cyc, SS + 2);
      end
    end
    check_events("basic");
    total++;
    if (busy_seen - bs !== NDEV) begin
      bad++;
      $display("FAIL basic busy cycles: got %0d want %0d", busy_seen - bs, NDEV);
    end
    check_cnt("basic");
    rd_dev = 2'd2; rd_addr = 4'hA;
    tick(1);
    total++;
    if (rd_data !== 8'h05) begin
      bad++;
      $display("FAIL basic read dev2 A: got %h want 05", rd_data);
    end
  endtask

  task automatic test_bad_len();
    logic [15:0] w [NDEV];
    int es;
    es = err_seen;
    rand_words(w);
    send_bits(w, 16*NDEV - 1, 3);
    tick(10);
    rand_words(w);
    send_bits(w, 16*NDEV + 1, 3);
    tick(15);
    total++;
    if (err_seen - es !== 2) begin
      bad++;
      $display("FAIL bad_len frame_err pulses: got %0d want 2", err_seen - es);
    end
    check_events("bad_len");
    check_cnt("bad_len");
    check_shadow("bad_len", 6);
  endtask

  task automatic test_noop();
    logic [15:0] w [NDEV];
    int bs;
    for (int i = 0; i < NDEV; i++) w[i] = {4'($urandom), 4'($urandom_range(1, 15)), 8'($urandom)};
    w[NDEV-1-1] = 16'h0000;
    bs = busy_seen;
    model_frame(w);
    send_bits(w, 16*NDEV, 4);
    tick(20);
    check_events("noop");
    total++;
    if (busy_seen - bs !== NDEV) begin
      bad++;
      $display("FAIL noop busy cycles: got %0d want %0d", busy_seen - bs, NDEV);
    end
    check_cnt("noop");
  endtask

  task automatic test_back_to_back();
    logic [15:0] wa [NDEV];
    logic [15:0] wb [NDEV];
    int es;
    es = err_seen;
    rand_words(wa);
    rand_words(wb);
    model_frame(wa);
    model_frame(wb);
    send_bits(wa, 16*NDEV, 3);
    tick(1);
    send_bits(wb, 16*NDEV, 3);
    tick(20);
    check_events("back_to_back");
    check_cnt("back_to_back");
    total++;
    if (err_seen - es !== 0) begin
      bad++;
      $display("FAIL back_to_back frame_err: got %0d want 0", err_seen - es);
    end
    check_shadow("back_to_back", 6);
  endtask

  task automatic test_idle_noise();
    int es, bs;
    es = err_seen;
    bs = busy_seen;
    leds_cs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      leds_in  = 1'($urandom);
      leds_clk = 1'b1; tick(3);
      leds_clk = 1'b0; tick(3);
    end
    leds_cs = 1'b0; tick(5);
    leds_cs = 1'b1; tick(15);
    check_events("idle_noise");
    total++;
    if ({err_seen - es, busy_seen - bs} !== {32'd0, 32'd0}) begin
      bad++;
      $display("FAIL idle_noise err/busy: got %0d/%0d want 0/0", err_seen - es, busy_seen - bs);
    end
    check_cnt("idle_noise");
  endtask

  task automatic test_random();
    logic [15:0] w [NDEV];
    for (int f = 0; f < 5; f++) begin
      rand_words(w);
      model_frame(w);
      send_bits(w, 16*NDEV, $urandom_range(3, 6));
      tick($urandom_range(15, 25));
      check_events("random");
      check_cnt("random");
    end
    check_shadow("random", 8);
  endtask

  task automatic test_reset_mid();
    logic [15:0] w [NDEV];
    int i;
    // Reset while shifting
    leds_cs = 1'b0;
    tick(3);
    for (int k = 0; k < 20; k++) begin
      leds_in = 1'($urandom);
      leds_clk = 1'b0; tick(3);
      leds_clk = 1'b1; tick(3);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_shift");
    do_reset();
    check_shadow("reset_mid_shift", 4);
    // Reset while committing
    rand_words(w);
    send_bits(w, 16*NDEV, 3);
    i = 0;
    while (i < 12 && !busy) begin
      tick(1);
      i++;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_commit busy wait: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_commit");
    do_reset();
    check_shadow("reset_mid_commit", 4);
    // Clean frame afterwards
    rand_words(w);
    model_frame(w);
    send_bits(w, 16*NDEV, 3);
    tick(20);
    check_events("after_reset");
    check_cnt("after_reset");
    check_shadow("after_reset", 6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_len();
    test_noop();
    test_back_to_back();
    test_idle_noise();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
